// File: rtl/sat_accum_pkg.sv
// Shared types and width helpers for the saturating message accumulator.
// Optional feature macro used by sat_accum: SAT_STATS_EN (saturation-event counter).
package sat_accum_pkg;

  // Frame-tracking states: no frame open / frame open.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

  // Accumulator width is the message width plus guard bits.
  function automatic int unsigned acc_width(input int unsigned w, input int unsigned ext);
    return w + ext;
  endfunction

endpackage

// File: rtl/sat_clamp.sv
// Combinational signed clamp from W_IN bits down to W_OUT bits.
// Ports:
//   i_value   : signed input, W_IN bits
//   i_sym     : 1 = symmetric range +/-(2^(W_OUT-1)-1), 0 = full two's-complement range
//   o_value_c : clamped value, W_OUT bits
//   o_flag_c  : high when the input was outside the selected range
module sat_clamp #(
  parameter int unsigned W_IN  = 13,
  parameter int unsigned W_OUT = 12
) (
  input  logic signed [W_IN-1:0]  i_value,
  input  logic                    i_sym,
  output logic signed [W_OUT-1:0] o_value_c,
  output logic                    o_flag_c
);

  localparam logic signed [W_IN-1:0] C_MAX =
    {{(W_IN-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
  localparam logic signed [W_IN-1:0] C_MIN =
    {{(W_IN-W_OUT+1){1'b1}}, {(W_OUT-1){1'b0}}};

  logic signed [W_IN-1:0] w_min;

  // Symmetric mode gives up the most negative code.
  assign w_min = i_sym ? (C_MIN + W_IN'(1)) : C_MIN;

  always_comb begin
    o_value_c = i_value[W_OUT-1:0];
    o_flag_c  = 1'b0;
    if (i_value > C_MAX) begin
      o_value_c = C_MAX[W_OUT-1:0];
      o_flag_c  = 1'b1;
    end else if (i_value < w_min) begin
      o_value_c = w_min[W_OUT-1:0];
      o_flag_c  = 1'b1;
    end
  end

endmodule

// File: rtl/sat_accum.sv
// Multi-channel saturating LLR accumulator: sums a frame of beats per lane in an
// extended-width register, arithmetic right shift on the last beat, saturates to
// message width. valid/ready on both sides.
// Optional macro SAT_STATS_EN adds the sat_count port/register.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : input beat handshake
//   in_data             : CHANNELS lanes of WIDTH bits, lane c at [c*WIDTH +: WIDTH]
//   in_first/in_last    : frame delimiters
//   shift, sym_mode     : normalisation shift and output range, taken on the last beat
//   out_valid/out_ready : result handshake
//   out_data, out_sat   : saturated results and per-lane saturation flags
//   sat_count           : frames with any saturation (SAT_STATS_EN only)
module sat_accum
  import sat_accum_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned EXTENDED_BITS = 4,
  parameter int unsigned CHANNELS      = 4,
`ifdef SAT_STATS_EN
  parameter int unsigned CNT_W         = 16,
`endif
  parameter int unsigned SHIFT_W       = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [CHANNELS*WIDTH-1:0]   in_data,
  input  logic                        in_first,
  input  logic                        in_last,
  input  logic [SHIFT_W-1:0]          shift,
  input  logic                        sym_mode,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [CHANNELS*WIDTH-1:0]   out_data,
  output logic [CHANNELS-1:0]         out_sat
`ifdef SAT_STATS_EN
  ,
  output logic [CNT_W-1:0]            sat_count
`endif
);

  localparam int unsigned AW = acc_width(WIDTH, EXTENDED_BITS);

  state_e                    r_state, w_state_next;
  logic signed [AW-1:0]      r_acc       [CHANNELS];
  logic signed [AW-1:0]      w_acc_next  [CHANNELS];
  logic signed [AW-1:0]      w_acc_clamp [CHANNELS];
  logic signed [AW-1:0]      w_shifted   [CHANNELS];
  logic signed [AW:0]        w_sum       [CHANNELS];
  logic signed [WIDTH-1:0]   w_out_val   [CHANNELS];
  logic [CHANNELS-1:0]       r_sticky, w_sticky_next;
  logic [CHANNELS-1:0]       w_acc_flag, w_out_flag, w_out_sat;
  logic [CHANNELS*WIDTH-1:0] w_out_data;
  logic                      w_fire, w_load, w_start;

  assign in_ready = !out_valid || out_ready;
  assign w_fire   = in_valid && in_ready;
  assign w_load   = w_fire && in_last;

  // Next state and frame-start decode.
  always_comb begin
    w_state_next = r_state;
    w_start      = (r_state == ST_IDLE) || in_first;
    if (w_fire) begin
      w_state_next = in_last ? ST_IDLE : ST_ACCUM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // Per-lane accumulate, normalise and output saturation.
  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_lane
    logic signed [WIDTH-1:0] w_beat;
    assign w_beat   = in_data[g*WIDTH +: WIDTH];
    assign w_sum[g] = (AW+1)'(r_acc[g]) + (AW+1)'(w_beat);

    sat_clamp #(.W_IN(AW+1), .W_OUT(AW)) u_acc_clamp (
      .i_value   (w_sum[g]),
      .i_sym     (1'b1),
      .o_value_c (w_acc_clamp[g]),
      .o_flag_c  (w_acc_flag[g])
    );

    // A frame start reloads the lane and forgets any earlier clamp.
    assign w_acc_next[g]    = w_start ? AW'(w_beat) : w_acc_clamp[g];
    assign w_sticky_next[g] = !w_start && (r_sticky[g] || w_acc_flag[g]);
    assign w_shifted[g]     = w_acc_next[g] >>> shift;

    sat_clamp #(.W_IN(AW), .W_OUT(WIDTH)) u_out_clamp (
      .i_value   (w_shifted[g]),
      .i_sym     (sym_mode),
      .o_value_c (w_out_val[g]),
      .o_flag_c  (w_out_flag[g])
    );

    assign w_out_sat[g]                  = w_out_flag[g] || w_sticky_next[g];
    assign w_out_data[g*WIDTH +: WIDTH]  = w_out_val[g];
  end

  // Accumulator and sticky flags update on every accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < int'(CHANNELS); c++) r_acc[c] <= '0;
      r_sticky <= '0;
    end else if (w_fire) begin
      for (int c = 0; c < int'(CHANNELS); c++) r_acc[c] <= w_acc_next[c];
      r_sticky <= w_sticky_next;
    end
  end

  // Output register: load on last beat, retire on out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
    end else if (w_load) begin
      out_valid <= 1'b1;
      out_data  <= w_out_data;
      out_sat   <= w_out_sat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef SAT_STATS_EN
  // Count frames with any saturation; holds at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count <= '0;
    end else if (w_load && (|w_out_sat) && (sat_count != '1)) begin
      sat_count <= sat_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_sat_accum.sv
// Self-checking bench for sat_accum (default parameters: 8-bit, 4 guard bits, 4 lanes).
module tb_sat_accum;

  localparam int CH   = 4;
  localparam int AMAX = 2047;
  localparam int OMAX = 127;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_first, in_last, sym_mode;
  logic [31:0] in_data;
  logic [1:0]  shift;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_sat;
`ifdef SAT_STATS_EN
  logic [15:0] sat_count;
`endif

  sat_accum dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_first  (in_first),
    .in_last   (in_last),
    .shift     (shift),
    .sym_mode  (sym_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
`ifdef SAT_STATS_EN
    ,
    .sat_count (sat_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  typedef struct {
    int nbeats;
    int val;
    int sh;
    bit sym;
    int exp_out;
    bit exp_sat;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  s;
  } res_t;

  vec_t tbl[7];
  res_t q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rep(input int v);
    logic [31:0] r;
    for (int c = 0; c < CH; c++) r[c*8 +: 8] = v[7:0];
    return r;
  endfunction

  // Floor division by 2^sh, written without shifts.
  function automatic int floor_div(input int a, input int sh);
    int d;
    d = 1;
    for (int i = 0; i < sh; i++) d = d * 2;
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic void bump_cnt();
    if (exp_cnt < 65535) exp_cnt++;
  endfunction

  task automatic drive_beat(input logic [31:0] d, input bit f, input bit l,
                            input int sh, input bit sym);
    in_data  = d;
    in_first = f;
    in_last  = l;
    shift    = 2'(sh);
    sym_mode = sym;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          open;
    int          macc[CH];
    bit          mst[CH];
    bit          acc_ok;
    res_t        r;
    logic [31:0] held;

    tbl[0] = '{1,  100,  0, 1'b0, 100,  1'b0};
    tbl[1] = '{4,  100,  0, 1'b0, 127,  1'b1};
    tbl[2] = '{4,  100,  2, 1'b0, 100,  1'b0};
    tbl[3] = '{1,  -128, 0, 1'b1, -127, 1'b1};
    tbl[4] = '{1,  -128, 0, 1'b0, -128, 1'b0};
    tbl[5] = '{40, 127,  3, 1'b0, 127,  1'b1};
    tbl[6] = '{40, 127,  4, 1'b0, 127,  1'b1};

    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    in_data = '0; shift = '0; sym_mode = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed frames: every lane carries the same value.
    for (int i = 0; i < 7; i++) begin
      for (int b = 0; b < tbl[i].nbeats; b++)
        drive_beat(rep(tbl[i].val), b == 0, b == tbl[i].nbeats - 1, tbl[i].sh, tbl[i].sym);
      check($sformatf("tbl%0d_valid", i), out_valid, 1);
      check($sformatf("tbl%0d_data", i), out_data, rep(tbl[i].exp_out));
      check($sformatf("tbl%0d_sat", i), out_sat, tbl[i].exp_sat ? 4'hF : 4'h0);
      if (tbl[i].exp_sat) bump_cnt();
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_retired", i), out_valid, 0);
    end
`ifdef SAT_STATS_EN
    check("tbl_sat_count", sat_count, exp_cnt);
`endif

    // Back-pressure: result held stable, then retire and load on one edge.
    out_ready = 1'b0;
    drive_beat(rep(5), 1'b1, 1'b1, 0, 1'b0);
    check("bp_loaded", out_valid, 1);
    in_data = rep(7); in_first = 1'b1; in_last = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_in_ready%0d", k), in_ready, 0);
      check($sformatf("bp_hold%0d", k), out_data, rep(5));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_up", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    check("bp_swap_valid", out_valid, 1);
    check("bp_swap_data", out_data, rep(7));
    @(posedge clk);
    #1;
    check("bp_drained", out_valid, 0);

    // Reset drops a pending result and a partial frame.
    out_ready = 1'b0;
    drive_beat(rep(33), 1'b1, 1'b1, 0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rst_pending_lost", out_valid, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    drive_beat(rep(50), 1'b1, 1'b0, 0, 1'b0);
    drive_beat(rep(50), 1'b0, 1'b0, 0, 1'b0);
    drive_beat(rep(50), 1'b0, 1'b0, 0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_data", out_data, 0);
    rst = 1'b0;
    exp_cnt = 0;
    @(posedge clk);
    #1;
    drive_beat(rep(10), 1'b0, 1'b1, 0, 1'b0);
    check("rst_new_frame", out_data, rep(10));
    check("rst_new_sat", out_sat, 0);
`ifdef SAT_STATS_EN
    check("rst_sat_count", sat_count, 0);
`endif
    @(posedge clk);
    #1;

    // Randomised traffic against a frame-level model.
    open = 1'b0;
    for (int c = 0; c < CH; c++) begin macc[c] = 0; mst[c] = 1'b0; end
    for (int cyc = 0; cyc < 1500; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = $urandom;
      if (cyc >= 700) begin
        in_data[7:0]  = 8'($urandom_range(100, 127));
        in_data[15:8] = 8'(-int'($urandom_range(100, 128)));
      end
      in_first  = ($urandom_range(0, 5) == 0);
      in_last   = ($urandom_range(0, (cyc < 700) ? 3 : 30) == 0);
      shift     = 2'($urandom_range(0, 3));
      sym_mode  = 1'($urandom_range(0, 1));
      #1;
      check("rnd_in_ready", in_ready, (q.size() == 0) || out_ready);
      check("rnd_out_valid", out_valid, q.size() != 0);
      acc_ok = in_valid && ((q.size() == 0) || out_ready);
      if (q.size() != 0 && out_ready) begin
        check("rnd_data", out_data, q[0].d);
        check("rnd_sat", out_sat, q[0].s);
        void'(q.pop_front());
      end
      if (acc_ok) begin
        for (int c = 0; c < CH; c++) begin
          int v;
          v = int'($signed(in_data[c*8 +: 8]));
          if (!open || in_first) begin
            macc[c] = v;
            mst[c]  = 1'b0;
          end else begin
            macc[c] = macc[c] + v;
            if (macc[c] > AMAX)       begin macc[c] = AMAX;  mst[c] = 1'b1; end
            else if (macc[c] < -AMAX) begin macc[c] = -AMAX; mst[c] = 1'b1; end
          end
        end
        if (in_last) begin
          for (int c = 0; c < CH; c++) begin
            int o, lo;
            bit cl;
            o  = floor_div(macc[c], int'(shift));
            lo = sym_mode ? -OMAX : -OMAX - 1;
            cl = 1'b0;
            if (o > OMAX)    begin o = OMAX; cl = 1'b1; end
            else if (o < lo) begin o = lo;   cl = 1'b1; end
            r.d[c*8 +: 8] = o[7:0];
            r.s[c]        = cl || mst[c];
          end
          q.push_back(r);
          if (r.s != 0) bump_cnt();
          open = 1'b0;
        end else begin
          open = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    if (q.size() != 0) begin
      check("drain_data", out_data, q[0].d);
      check("drain_sat", out_sat, q[0].s);
      void'(q.pop_front());
    end
    @(posedge clk);
    #1;
    check("drain_empty", out_valid, 0);
`ifdef SAT_STATS_EN
    check("rnd_sat_count", sat_count, exp_cnt);
`endif
    held = out_data;
    check("final_idle_ready", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
